// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory port between
// instruction fetch and data access, with halt handling and an ack watchdog.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ireq,
    input  logic [AW-1:0] iaddr,
    output logic          ivalid,
    output logic [DW-1:0] irdata,
    output logic          istall,
    input  logic          dreq,
    input  logic          dwe,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dwdata,
    output logic          dvalid,
    output logic [DW-1:0] drdata,
    output logic          dstall,
    input  logic          halt,
    output logic          halted,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [1:0]    state;
    logic          lastGrant;
    logic [CW-1:0] counter;
    logic          haltPending;

    logic          busy;
    logic          done;
    logic          timedOut;
    logic          grantD;
    logic [DW-1:0] readData;

    always_comb begin
        busy     = (state == BUSY_I) || (state == BUSY_D);
        done     = busy && (mem_ack || (counter == LAST_COUNT));
        timedOut = busy && !mem_ack && (counter == LAST_COUNT);
        grantD   = dreq && (!ireq || (lastGrant == GRANT_I));
        // An aborted transaction returns zero rather than whatever is on the bus.
        readData = mem_ack ? mem_rdata : '0;
    end

    assign ivalid = (state == BUSY_I) && done;
    assign dvalid = (state == BUSY_D) && done;
    assign irdata = readData;
    assign drdata = readData;
    assign istall = ireq & ~ivalid;
    assign dstall = dreq & ~dvalid;
    assign halted = (state == HALTED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            lastGrant   <= GRANT_I;
            counter     <= '0;
            haltPending <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (halt) begin
                        state <= HALTED;
                    end else if (ireq || dreq) begin
                        mem_req <= 1'b1;
                        counter <= '0;
                        if (grantD) begin
                            lastGrant <= GRANT_D;
                            mem_addr  <= daddr;
                            mem_we    <= dwe;
                            mem_wdata <= dwdata;
                            state     <= BUSY_D;
                        end else begin
                            lastGrant <= GRANT_I;
                            mem_addr  <= iaddr;
                            mem_we    <= 1'b0;
                            state     <= BUSY_I;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    // A halt seen at any point in the transaction is honoured once it retires.
                    if (done) begin
                        mem_req     <= 1'b0;
                        counter     <= '0;
                        haltPending <= 1'b0;
                        state       <= (halt || haltPending) ? HALTED : IDLE;
                        if (timedOut) begin
                            err <= 1'b1;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                        if (halt) begin
                            haltPending <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= HALTED;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the bench drives mem_ack
// by hand so every expected value is fixed cycle by cycle.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        ireq;
    logic [31:0] iaddr;
    logic        ivalid;
    logic [31:0] irdata;
    logic        istall;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        dvalid;
    logic [31:0] drdata;
    logic        dstall;
    logic        halt;
    logic        halted;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;

    int testsRun;
    int testsFailed;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .ireq(ireq), .iaddr(iaddr), .ivalid(ivalid), .irdata(irdata), .istall(istall),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
        .dvalid(dvalid), .drdata(drdata), .dstall(dstall),
        .halt(halt), .halted(halted),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge; outputs are checked 1 time unit later.
    task automatic applyStimulus(input logic i, input logic d, input logic h, input logic a);
        @(posedge clk);
        #1;
        ireq    = i;
        dreq    = d;
        halt    = h;
        mem_ack = a;
        #1;
    endtask

    task automatic doReset();
        ireq = 1'b0; dreq = 1'b0; halt = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        testsRun = 0; testsFailed = 0;
        reset_n = 1'b0;
        ireq = 0; iaddr = '0; dreq = 0; dwe = 0; daddr = '0; dwdata = '0;
        halt = 0; mem_rdata = '0; mem_ack = 0;

        #3;
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        #9 reset_n = 1'b1;

        // Fetch only, ack three cycles after mem_req rises
        iaddr = 32'h40;
        applyStimulus(1, 0, 0, 0);
        checkOutput("f_idle_req", 32'(mem_req), 32'd0);
        checkOutput("f_idle_stall", 32'(istall), 32'd1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 0, 0);
            checkOutput("f_busy_req", 32'(mem_req), 32'd1);
            checkOutput("f_busy_valid", 32'(ivalid), 32'd0);
            checkOutput("f_busy_stall", 32'(istall), 32'd1);
        end
        checkOutput("f_addr", mem_addr, 32'h40);
        checkOutput("f_we", 32'(mem_we), 32'd0);
        mem_rdata = 32'h20080005;
        applyStimulus(1, 0, 0, 1);
        checkOutput("f_valid", 32'(ivalid), 32'd1);
        checkOutput("f_rdata", irdata, 32'h20080005);
        checkOutput("f_stall_done", 32'(istall), 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("f_req_drop", 32'(mem_req), 32'd0);
        checkOutput("f_valid_drop", 32'(ivalid), 32'd0);

        // Collision out of reset: data first, fetch after an idle cycle
        doReset();
        iaddr = 32'h80; dwe = 1; daddr = 32'h100; dwdata = 32'hDEADBEEF;
        applyStimulus(1, 1, 0, 0);
        checkOutput("c1_dstall", 32'(dstall), 32'd1);
        applyStimulus(1, 1, 0, 1);
        checkOutput("c1_d_req", 32'(mem_req), 32'd1);
        checkOutput("c1_d_we", 32'(mem_we), 32'd1);
        checkOutput("c1_d_addr", mem_addr, 32'h100);
        checkOutput("c1_d_wdata", mem_wdata, 32'hDEADBEEF);
        checkOutput("c1_dvalid", 32'(dvalid), 32'd1);
        checkOutput("c1_ivalid", 32'(ivalid), 32'd0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("c1_gap_req", 32'(mem_req), 32'd0);
        checkOutput("c1_gap_istall", 32'(istall), 32'd1);
        mem_rdata = 32'h11112222;
        applyStimulus(1, 0, 0, 1);
        checkOutput("c1_i_addr", mem_addr, 32'h80);
        checkOutput("c1_i_we", 32'(mem_we), 32'd0);
        checkOutput("c1_i_wdata_hold", mem_wdata, 32'hDEADBEEF);
        checkOutput("c1_ivalid", 32'(ivalid), 32'd1);
        checkOutput("c1_irdata", irdata, 32'h11112222);
        applyStimulus(0, 0, 0, 0);

        // Data-only load with fast ack: mem_req is a single-cycle pulse
        dwe = 0; daddr = 32'h104; mem_rdata = 32'hCAFE0001;
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("fa_req", 32'(mem_req), 32'd1);
        checkOutput("fa_dvalid", 32'(dvalid), 32'd1);
        checkOutput("fa_drdata", drdata, 32'hCAFE0001);
        checkOutput("fa_we", 32'(mem_we), 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("fa_req_pulse", 32'(mem_req), 32'd0);

        // Second collision after a data grant: fetch wins
        iaddr = 32'h84; daddr = 32'h108;
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("c2_i_addr", mem_addr, 32'h84);
        checkOutput("c2_dstall", 32'(dstall), 32'd1);
        applyStimulus(1, 1, 0, 1);
        checkOutput("c2_ivalid", 32'(ivalid), 32'd1);
        checkOutput("c2_dvalid", 32'(dvalid), 32'd0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("c2_d_addr", mem_addr, 32'h108);
        checkOutput("c2_dvalid2", 32'(dvalid), 32'd1);
        applyStimulus(0, 0, 0, 0);

        // Timeout: no ack, abort on the 16th busy cycle
        daddr = 32'h200; mem_rdata = 32'h12345678;
        applyStimulus(0, 1, 0, 0);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, 1, 0, 0);
            if (k < 15) begin
                checkOutput("to_wait_dvalid", 32'(dvalid), 32'd0);
            end else begin
                checkOutput("to_dvalid", 32'(dvalid), 32'd1);
                checkOutput("to_drdata", drdata, 32'd0);
                checkOutput("to_err_pre", 32'(err), 32'd0);
            end
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("to_err", 32'(err), 32'd1);
        checkOutput("to_req_drop", 32'(mem_req), 32'd0);
        daddr = 32'h204; mem_rdata = 32'h0BADF00D;
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("to_after_dvalid", 32'(dvalid), 32'd1);
        checkOutput("to_after_drdata", drdata, 32'h0BADF00D);
        applyStimulus(0, 0, 0, 0);
        checkOutput("to_err_sticky", 32'(err), 32'd1);

        // Halt during a load in flight
        daddr = 32'h300; mem_rdata = 32'h55AA55AA;
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0);
        checkOutput("h_busy_req", 32'(mem_req), 32'd1);
        checkOutput("h_busy_halted", 32'(halted), 32'd0);
        applyStimulus(0, 1, 1, 1);
        checkOutput("h_dvalid", 32'(dvalid), 32'd1);
        checkOutput("h_drdata", drdata, 32'h55AA55AA);
        applyStimulus(0, 0, 0, 0);
        checkOutput("h_halted", 32'(halted), 32'd1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 0, (k == 2) ? 1'b1 : 1'b0);
            checkOutput("h_no_req", 32'(mem_req), 32'd0);
            checkOutput("h_istall", 32'(istall), 32'd1);
            checkOutput("h_ivalid", 32'(ivalid), 32'd0);
        end
        checkOutput("h_still_halted", 32'(halted), 32'd1);

        // Reset pulsed mid BUSY_D, then a stray ack
        doReset();
        checkOutput("r_err_clr", 32'(err), 32'd0);
        checkOutput("r_halted_clr", 32'(halted), 32'd0);
        dwe = 1; daddr = 32'h400; dwdata = 32'hA5A5A5A5;
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("r_busy_req", 32'(mem_req), 32'd1);
        checkOutput("r_busy_addr", mem_addr, 32'h400);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("r_async_req", 32'(mem_req), 32'd0);
        checkOutput("r_async_addr", mem_addr, 32'd0);
        checkOutput("r_async_wdata", mem_wdata, 32'd0);
        checkOutput("r_async_we", 32'(mem_we), 32'd0);
        checkOutput("r_async_dvalid", 32'(dvalid), 32'd0);
        dreq = 0;
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(0, 0, 0, 1);
        checkOutput("r_stray_dvalid", 32'(dvalid), 32'd0);
        checkOutput("r_stray_ivalid", 32'(ivalid), 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("r_stray_req", 32'(mem_req), 32'd0);
        checkOutput("r_stray_err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
